fifo_ctrl: RTL and testbench
============================

// Module: fifo_ctrl
// PURPOSE
//  Pointer/flag controller sitting directly upstream of the register-file storage
//  (sync write port, async read port) to form a FIFO. Drives the storage's write
//  enable, write address and read address; tracks full/empty/occupancy.
//  Flags illegal accesses with sticky error bits. Holds no data itself.
// PARAMETERS
//  ADDR_WIDTH  7   storage address width; depth = 2**ADDR_WIDTH entries
//  AF_THRESH   120 almost_full asserted when level >= AF_THRESH
//  AE_THRESH   8   almost_empty asserted when level <= AE_THRESH
// PORTS
//  clk           in   1             rising-edge clock
//  reset         in   1             async, active-high reset
//  wr            in   1             push request (data presented to storage data_w)
//  rd            in   1             pop request (head word is on storage data_r)
//  clr_err       in   1             clear overflow/underflow sticky bits
//  we            out  1             storage write enable (combinational)
//  w_addr        out  ADDR_WIDTH    storage write address = write pointer
//  r_addr        out  ADDR_WIDTH    storage read address = read pointer (head)
//  full          out  1             level == 2**ADDR_WIDTH
//  empty         out  1             level == 0
//  almost_full   out  1             see CONFIGURATION
//  almost_empty  out  1             see CONFIGURATION
//  level         out  ADDR_WIDTH+1  occupancy, 0..2**ADDR_WIDTH
//  overflow      out  1             sticky: push attempted and rejected
//  underflow     out  1             sticky: pop attempted while empty
// BEHAVIOUR
//  - Reset (async, immediate): pointers=0, level=0, empty=1, full=0, almost_full=0,
//    almost_empty=1, overflow=0, underflow=0. Reset mid-operation discards contents.
//  - All state registered on rising clk; flags/level reflect state after the edge.
//  - push_ok = wr & (~full | rd);  pop_ok = rd & ~empty;  we = push_ok (comb).
//  - push_ok: w_ptr <= w_ptr+1; pop_ok: r_ptr <= r_ptr+1; both wrap modulo depth.
//  - level: +1 push only, -1 pop only, unchanged both/neither. Never exceeds depth.
//  - full/empty derived from next level, registered (no extra MSB pointer scheme).
//  - Read latency 0: head word valid on storage data_r whenever empty=0; pop
//    consumes it at the edge.
//  - wr&rd while full: both proceed, level stays depth, no overflow.
//  - wr&rd while empty: write only, level -> 1, underflow set.
//  - wr while full (rd=0): rejected, we=0, overflow set.
//  - rd while empty: ignored, underflow set.
//  - clr_err clears both sticky bits; a new error in the same cycle wins (stays 1).
//  - Only states: EMPTY (level 0), PARTIAL, FULL (level depth); transitions follow level.
// CONFIGURATION
//  Macro FIFO_CTRL_LEVEL_EN:
//  - defined: level output driven by registered counter; almost_full/almost_empty
//    registered from next level against AF_THRESH/AE_THRESH.
//  - undefined: no counter; full/empty from pointer equality plus registered
//    last-op bit; level tied 0; almost_full = full; almost_empty = empty.
//  - Ports identical in both builds; full/empty/error behaviour identical.
// TESTING (ADDR_WIDTH=3, AF_THRESH=6, AE_THRESH=1, LEVEL_EN defined)
//  - Reset mid-stream after 3 pushes -> empty=1, level=0, r_addr=w_addr=0, errors 0.
//  - 8 pushes from empty -> full=1 after 8th edge, level=8, almost_full from level 6,
//    w_addr wraps 7->0.
//  - 9th push while full -> we=0, w_addr unchanged, overflow=1 until clr_err.
//  - wr&rd while full -> level stays 8, w_addr and r_addr both +1, overflow=0.
//  - rd on empty, then wr&rd on empty -> underflow=1, level=1, r_addr unchanged.
//  - clr_err with simultaneous rd on empty -> underflow stays 1; clr_err alone -> 0.

Source files
------------

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a FIFO built around a register file (sync write, async read).
// Optional FIFO_CTRL_LEVEL_EN adds the occupancy counter and threshold-based almost flags.
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 7,
    parameter int AF_THRESH  = 120,
    parameter int AE_THRESH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    // Handshake: a push is taken when wr=1 and the FIFO is not full, or when a pop
    // frees a slot in the same cycle; a pop is taken when rd=1 and the FIFO is not
    // empty. Both take effect on the rising clk edge; we mirrors the push decision.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_next;
    logic [ADDR_WIDTH-1:0] r_ptr_next;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  overflow_next;
    logic                  underflow_next;

    always_comb begin
        push_ok        = wr & ((state != ST_FULL) | rd);
        pop_ok         = rd & (state != ST_EMPTY);
        w_ptr_next     = push_ok ? w_ptr + ADDR_WIDTH'(1) : w_ptr;
        r_ptr_next     = pop_ok  ? r_ptr + ADDR_WIDTH'(1) : r_ptr;
        // A fresh error in the clearing cycle keeps its bit set.
        overflow_next  = (overflow & ~clr_err) | (wr & ~push_ok);
        underflow_next = (underflow & ~clr_err) | (rd & (state == ST_EMPTY));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_EMPTY;
            w_ptr     <= '0;
            r_ptr     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_next;
            w_ptr     <= w_ptr_next;
            r_ptr     <= r_ptr_next;
            overflow  <= overflow_next;
            underflow <= underflow_next;
        end
    end

    assign we     = push_ok;
    assign w_addr = w_ptr;
    assign r_addr = r_ptr;
    assign full   = (state == ST_FULL);
    assign empty  = (state == ST_EMPTY);

`ifdef FIFO_CTRL_LEVEL_EN
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_L  = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_L  = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [ADDR_WIDTH:0] level_q;
    logic [ADDR_WIDTH:0] level_next;
    logic                af_q;
    logic                ae_q;

    always_comb begin
        level_next = level_q;
        state_next = ST_PARTIAL;
        if (push_ok & ~pop_ok) begin
            level_next = level_q + (ADDR_WIDTH+1)'(1);
        end else if (pop_ok & ~push_ok) begin
            level_next = level_q - (ADDR_WIDTH+1)'(1);
        end
        if (level_next == '0) begin
            state_next = ST_EMPTY;
        end else if (level_next == DEPTH) begin
            state_next = ST_FULL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= '0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            level_q <= level_next;
            af_q    <= (level_next >= AF_L);
            ae_q    <= (level_next <= AE_L);
        end
    end

    assign level        = level_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
`else
    // Equal pointers are ambiguous; the direction of the last single-sided op resolves it.
    logic last_push;
    logic last_push_next;

    always_comb begin
        last_push_next = last_push;
        state_next     = ST_PARTIAL;
        if (push_ok & ~pop_ok) begin
            last_push_next = 1'b1;
        end else if (pop_ok & ~push_ok) begin
            last_push_next = 1'b0;
        end
        if (w_ptr_next == r_ptr_next) begin
            state_next = last_push_next ? ST_FULL : ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_push <= 1'b0;
        end else begin
            last_push <= last_push_next;
        end
    end

    assign level        = '0;
    assign almost_full  = full;
    assign almost_empty = empty;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl (ADDR_WIDTH=3, AF_THRESH=6, AE_THRESH=1): directed
// table, async-reset sequence and random traffic against a queue-based occupancy model.
module tb_fifo_ctrl;

    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr;
    logic          rd;
    logic          clr_err;
    logic          we;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] r_addr;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          underflow;

    fifo_ctrl #(.ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .clr_err(clr_err),
        .we(we), .w_addr(w_addr), .r_addr(r_addr), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
        .overflow(overflow), .underflow(underflow)
    );

    // clock/reset block
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // scoreboard: each entry is the storage address a still-queued word was written to
    logic [AW-1:0] exp_q[$];
    int            wp;
    int            rp;
    bit            m_of;
    bit            m_uf;

    typedef struct {
        logic w;
        logic r;
        logic c;
        int   lvl;
        int   wa;
        int   ra;
        logic of;
        logic uf;
        logic we;
    } vec_t;

    vec_t tbl[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        wp   = 0;
        rp   = 0;
        m_of = 1'b0;
        m_uf = 1'b0;
    endtask

    task automatic check_state(input string tag, input int lvl, input int wa, input int ra,
                               input logic of, input logic uf);
        int   el;
        logic eaf;
        logic eae;
`ifdef FIFO_CTRL_LEVEL_EN
        el  = lvl;
        eaf = (lvl >= AF);
        eae = (lvl <= AE);
`else
        el  = 0;
        eaf = (lvl == DEPTH);
        eae = (lvl == 0);
`endif
        check({tag, ".level"}, 32'(level), el);
        check({tag, ".full"}, 32'(full), 32'(lvl == DEPTH));
        check({tag, ".empty"}, 32'(empty), 32'(lvl == 0));
        check({tag, ".almost_full"}, 32'(almost_full), 32'(eaf));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(eae));
        check({tag, ".w_addr"}, 32'(w_addr), wa);
        check({tag, ".r_addr"}, 32'(r_addr), ra);
        check({tag, ".overflow"}, 32'(overflow), 32'(of));
        check({tag, ".underflow"}, 32'(underflow), 32'(uf));
    endtask

    // driver: present one request at negedge, check we/head, advance the model, step the clock
    task automatic drive(input logic w, input logic r, input logic c, output logic we_seen);
        bit was_full;
        bit was_empty;
        bit push;
        bit pop;
        @(negedge clk);
        wr      = w;
        rd      = r;
        clr_err = c;
        #1;
        was_full  = (exp_q.size() == DEPTH);
        was_empty = (exp_q.size() == 0);
        push      = w && (!was_full || r);
        pop       = r && !was_empty;
        we_seen   = we;
        check("we", 32'(we), 32'(push));
        if (!was_empty) check("head", 32'(r_addr), 32'(exp_q[0]));
        if (pop) begin
            void'(exp_q.pop_front());
            rp = (rp + 1) % DEPTH;
        end
        if (push) begin
            exp_q.push_back(AW'(wp));
            wp = (wp + 1) % DEPTH;
        end
        m_of = (m_of && !c) || (w && !push);
        m_uf = (m_uf && !c) || (r && was_empty);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic we_seen;
        int   pw;
        int   pr;

        // directed vectors from a fresh reset: {wr, rd, clr, level, w_addr, r_addr, of, uf, we}
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1, 1, 0, 1'b0, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1, 1, 0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 0, 1, 1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 0, 1, 1, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 0, 1, 1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1, 2, 1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 2, 3, 1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 3, 4, 1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 4, 5, 1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 5, 6, 1, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 6, 7, 1, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 7, 0, 1, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 8, 1, 1, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 8, 1, 1, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 8, 2, 2, 1'b1, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 8, 2, 2, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 8, 3, 3, 1'b0, 1'b0, 1'b1};

        reset   = 1'b1;
        wr      = 1'b0;
        rd      = 1'b0;
        clr_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_state("reset", 0, 0, 0, 1'b0, 1'b0);

        // reset mid-stream after three pushes, asserted away from any clock edge
        repeat (3) drive(1'b1, 1'b0, 1'b0, we_seen);
        check_state("three_push", 3, 3, 0, 1'b0, 1'b0);
        @(negedge clk);
        wr     = 1'b0;
        reset  = 1'b1;
        #1;
        model_reset();
        check_state("async_reset", 0, 0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_state("reset_hold", 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].w, tbl[i].r, tbl[i].c, we_seen);
            check($sformatf("tbl%0d.we", i), 32'(we_seen), 32'(tbl[i].we));
            check_state($sformatf("tbl%0d", i), tbl[i].lvl, tbl[i].wa, tbl[i].ra,
                        tbl[i].of, tbl[i].uf);
        end

        // random traffic; push/pop bias shifts every 200 cycles to reach both extremes
        pw = 50;
        pr = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                pw = $urandom_range(15, 85);
                pr = 100 - pw;
            end
            drive(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
                  ($urandom_range(0, 99) < 6), we_seen);
            check_state("rand", exp_q.size(), wp, rp, m_of, m_uf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
